// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU arbiter slice: opcode values, arbiter FSM
// state encoding, the bit positions of the captured ALU flags and a helper
// that packs the three flag bits.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_ADD_U = 3'b000;
  localparam logic [2:0] OP_ADD_S = 3'b001;
  localparam logic [2:0] OP_SUB_U = 3'b010;
  localparam logic [2:0] OP_SUB_S = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_XOR   = 3'b110;
  localparam logic [2:0] OP_SHR2  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arbState_t;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;

  // Places the ALU status bits into the {overflow, carryout, zero} response layout.
  function automatic logic [2:0] packFlags(input logic ovf, input logic carry, input logic zero);
    logic [2:0] flags;
    flags            = '0;
    flags[FLAG_OVF]  = ovf;
    flags[FLAG_CARRY] = carry;
    flags[FLAG_ZERO] = zero;
    return flags;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker. Starting one position above the previous
// winner and wrapping around, it returns the first asserted request as a
// one-hot grant plus its binary index. No state lives here, so the block can be
// reused by any unit that keeps its own last-grant register.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_lastGrant,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_index,
  output logic            o_any
);

  // Walk the requesters in priority order beginning just after the last winner.
  always_comb begin
    int idx;
    o_grant = '0;
    o_index = '0;
    o_any   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(i_lastGrant) + k) % NREQ;
      if (!o_any && i_req[IW'(idx)]) begin
        o_grant[IW'(idx)] = 1'b1;
        o_index           = IW'(idx);
        o_any             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU among NREQ requesters. A request is accepted only
// while idle, the ALU inputs are held while the operation is in flight, and the
// result is captured with its flags and the issuing requester's id, then
// presented until the consumer takes it.
// Optional build macro: ALU_ARB_STATS_EN adds stat_ops, per-requester 16-bit
// saturating counts of completed responses.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int NUMBITS = 16,
  parameter int NREQ    = 4,
  parameter int ALU_LAT = 1,
  localparam int IW     = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*NUMBITS-1:0] req_a,
  input  logic [NREQ*NUMBITS-1:0] req_b,
  input  logic [NREQ*3-1:0]       req_op,
  output logic [NUMBITS-1:0]      alu_a,
  output logic [NUMBITS-1:0]      alu_b,
  output logic [2:0]              alu_opcode,
  input  logic [NUMBITS-1:0]      alu_result,
  input  logic                    alu_carryout,
  input  logic                    alu_overflow,
  input  logic                    alu_zero,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IW-1:0]           rsp_id,
  output logic [NUMBITS-1:0]      rsp_result,
  output logic [2:0]              rsp_flags
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]      stat_ops
`endif
);

  localparam logic [2:0] LAT = 3'(ALU_LAT);

  arbState_t            r_state;
  arbState_t            w_nextState;
  logic [IW-1:0]        r_lastGrant;
  logic [IW-1:0]        r_busyId;
  logic [2:0]           r_cnt;
  logic [NREQ-1:0]      w_grant;
  logic [IW-1:0]        w_grantIdx;
  logic                 w_anyReq;
  logic                 w_accept;
  logic                 w_capture;
  logic                 w_rspDone;
  logic [NUMBITS-1:0]   w_selA;
  logic [NUMBITS-1:0]   w_selB;
  logic [2:0]           w_selOp;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rrArbiter (
    .i_req      (req_valid),
    .i_lastGrant(r_lastGrant),
    .o_grant    (w_grant),
    .o_index    (w_grantIdx),
    .o_any      (w_anyReq)
  );

  assign w_selA  = req_a[w_grantIdx*NUMBITS +: NUMBITS];
  assign w_selB  = req_b[w_grantIdx*NUMBITS +: NUMBITS];
  assign w_selOp = req_op[w_grantIdx*3 +: 3];

  // Advance the arbiter FSM; reset abandons any operation in progress.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Idle waits for a request, busy waits out the ALU latency, resp waits for the consumer.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (w_anyReq) w_nextState = BUSY;
      BUSY:    if (r_cnt == 3'd0) w_nextState = RESP;
      RESP:    if (rsp_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Decode handshakes and strobes from the current state.
  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_rspDone = 1'b0;
    unique case (r_state)
      IDLE: begin
        req_ready = w_grant;
        w_accept  = w_anyReq;
      end
      BUSY:    w_capture = (r_cnt == 3'd0);
      RESP: begin
        rsp_valid = 1'b1;
        w_rspDone = rsp_ready;
      end
      default: ;
    endcase
  end

  // Latch the winning operands on accept, count down the ALU latency and capture the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_opcode  <= '0;
      r_lastGrant <= IW'(NREQ - 1);
      r_busyId    <= '0;
      r_cnt       <= '0;
      rsp_id      <= '0;
      rsp_result  <= '0;
      rsp_flags   <= '0;
    end else begin
      if (w_accept) begin
        alu_a       <= w_selA;
        alu_b       <= w_selB;
        alu_opcode  <= w_selOp;
        r_lastGrant <= w_grantIdx;
        r_busyId    <= w_grantIdx;
        r_cnt       <= LAT;
      end
      if (r_state == BUSY && r_cnt != 3'd0) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_capture) begin
        rsp_id     <= r_busyId;
        rsp_result <= alu_result;
        rsp_flags  <= packFlags(alu_overflow, alu_carryout, alu_zero);
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [15:0] r_statCnt [NREQ];

  // Count completed responses per requester, holding at the maximum value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) r_statCnt[i] <= '0;
    end else if (w_rspDone && r_statCnt[rsp_id] != 16'hFFFF) begin
      r_statCnt[rsp_id] <= r_statCnt[rsp_id] + 16'd1;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    assign stat_ops[g*16 +: 16] = r_statCnt[g];
  end
`else
  // Without the statistics option the arbiter carries no counters.
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with NUMBITS=16, NREQ=4, ALU_LAT=1. A small
// registered ALU model stands in for the team ALU. Inputs change on the falling
// edge and outputs are sampled 1ns after it. Define ALU_ARB_STATS_EN to also
// exercise the statistics counters.
`timescale 1ns/1ps
module tb_alu_arbiter;
  import alu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [11:0] req_op = '0;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_result = '0;
  logic        alu_carryout = 1'b0;
  logic        alu_overflow = 1'b0;
  logic        alu_zero = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_flags;
`ifdef ALU_ARB_STATS_EN
  logic [63:0] stat_ops;
`endif

  int errors = 0;
  int checks = 0;

  alu_arbiter #(
    .NUMBITS(16),
    .NREQ(4),
    .ALU_LAT(1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_opcode  (alu_opcode),
    .alu_result  (alu_result),
    .alu_carryout(alu_carryout),
    .alu_overflow(alu_overflow),
    .alu_zero    (alu_zero),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_flags   (rsp_flags)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_ops    (stat_ops)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ALU: {overflow, carry, zero, result} for one opcode.
  function automatic logic [18:0] aluEval(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] w;
    logic [15:0] r;
    logic c;
    logic v;
    w = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD_U, OP_ADD_S: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[15:0];
        c = w[16];
        if (op == OP_ADD_S) v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      OP_SUB_U, OP_SUB_S: begin
        w = {1'b0, a} - {1'b0, b};
        r = w[15:0];
        c = w[16];
        if (op == OP_SUB_S) v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = a >> 2;
    endcase
    return {v, c, (r == 16'h0000), r};
  endfunction

  // One-cycle registered ALU stand-in.
  always @(posedge clk) begin
    logic [18:0] o;
    o = aluEval(alu_opcode, alu_a, alu_b);
    alu_overflow <= o[18];
    alu_carryout <= o[17];
    alu_zero     <= o[16];
    alu_result   <= o[15:0];
  end

  task automatic applyStimulus(input int idx, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    req_a[idx*16 +: 16] = a;
    req_b[idx*16 +: 16] = b;
    req_op[idx*3 +: 3]  = op;
    req_valid[idx]      = 1'b1;
  endtask

  task automatic dropRequest(input int idx);
    req_valid[idx] = 1'b0;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    req_valid = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Issue one op from a lone requester with rsp_ready high and collect its response.
  task automatic issueAndCollect(input int idx, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                 output logic [3:0] readySeen, output int cycles,
                                 output logic [1:0] id, output logic [15:0] res, output logic [2:0] flags);
    @(negedge clk);
    rsp_ready = 1'b1;
    applyStimulus(idx, op, a, b);
    #1 readySeen = req_ready;
    @(negedge clk);
    dropRequest(idx);
    cycles = -1;
    for (int k = 1; k <= 20; k++) begin
      #1;
      if (rsp_valid === 1'b1) begin
        cycles = k - 1;
        break;
      end
      @(negedge clk);
    end
    id    = rsp_id;
    res   = rsp_result;
    flags = rsp_flags;
  endtask

  task automatic test_reset();
    pulseReset();
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    checks++;
    if (rsp_id !== 2'd0 || rsp_result !== 16'h0000 || rsp_flags !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_rsp_fields got id=%0d res=%h flags=%b want 0/0000/000", rsp_id, rsp_result, rsp_flags);
    end
    checks++;
    if (alu_a !== 16'h0000 || alu_b !== 16'h0000 || alu_opcode !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_alu_regs got a=%h b=%h op=%b want 0", alu_a, alu_b, alu_opcode);
    end
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_req_ready got=%b want=0000", req_ready); end
  endtask

  task automatic test_single_op();
    logic [3:0] rdy; int cyc; logic [1:0] id; logic [15:0] res; logic [2:0] fl;
    issueAndCollect(0, OP_ADD_U, 16'h0003, 16'h0004, rdy, cyc, id, res, fl);
    checks++;
    if (rdy !== 4'b0001) begin errors++; $display("[TB] FAIL single_ready got=%b want=0001", rdy); end
    checks++;
    if (cyc != 2) begin errors++; $display("[TB] FAIL single_latency got=%0d want=2", cyc); end
    checks++;
    if (id !== 2'd0) begin errors++; $display("[TB] FAIL single_id got=%0d want=0", id); end
    checks++;
    if (res !== 16'h0007) begin errors++; $display("[TB] FAIL single_result got=%h want=0007", res); end
    checks++;
    if (fl !== 3'b000) begin errors++; $display("[TB] FAIL single_flags got=%b want=000", fl); end
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_rsp_drop got=%b want=0", rsp_valid); end
  endtask

  task automatic test_wrap_zero();
    logic [3:0] rdy; int cyc; logic [1:0] id; logic [15:0] res; logic [2:0] fl;
    issueAndCollect(2, OP_ADD_U, 16'hFFFF, 16'h0001, rdy, cyc, id, res, fl);
    checks++;
    if (rdy !== 4'b0100) begin errors++; $display("[TB] FAIL wrap_ready got=%b want=0100", rdy); end
    checks++;
    if (cyc != 2) begin errors++; $display("[TB] FAIL wrap_latency got=%0d want=2", cyc); end
    checks++;
    if (id !== 2'd2) begin errors++; $display("[TB] FAIL wrap_id got=%0d want=2", id); end
    checks++;
    if (res !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_result got=%h want=0000", res); end
    checks++;
    if (fl !== 3'b011) begin errors++; $display("[TB] FAIL wrap_flags got=%b want=011", fl); end
  endtask

  task automatic test_fairness();
    int expOrder [5] = '{0, 1, 2, 3, 0};
    logic [15:0] expRes [4] = '{16'hF000, 16'h0FF0, 16'h0000, 16'h2001};
    logic [2:0] expFl [4] = '{3'b000, 3'b000, 3'b001, 3'b000};
    int wins [4] = '{0, 0, 0, 0};
    logic found;
    logic [3:0] rdy;
    pulseReset();
    rsp_ready = 1'b1;
    applyStimulus(0, OP_AND,  16'hF0F0, 16'hFF00);
    applyStimulus(1, OP_OR,   16'h00F0, 16'h0F00);
    applyStimulus(2, OP_XOR,  16'hAAAA, 16'hAAAA);
    applyStimulus(3, OP_SHR2, 16'h8004, 16'h0000);
    for (int n = 0; n < 5; n++) begin
      found = 1'b0;
      rdy = '0;
      for (int t = 0; t < 12 && !found; t++) begin
        #1;
        if (req_ready !== 4'b0000) begin found = 1'b1; rdy = req_ready; end
        else @(negedge clk);
      end
      checks++;
      if (rdy !== (4'b0001 << expOrder[n])) begin
        errors++; $display("[TB] FAIL fair_grant%0d got=%b want=%b", n, rdy, 4'b0001 << expOrder[n]);
      end
      if (n < 4) for (int r = 0; r < 4; r++) if (rdy[r]) wins[r]++;
      for (int t = 0; t < 12; t++) begin
        @(negedge clk);
        #1;
        if (rsp_valid === 1'b1) break;
      end
      checks++;
      if (rsp_id !== 2'(expOrder[n]) || rsp_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL fair_id%0d got=%0d valid=%b want=%0d", n, rsp_id, rsp_valid, expOrder[n]);
      end
      checks++;
      if (rsp_result !== expRes[expOrder[n]] || rsp_flags !== expFl[expOrder[n]]) begin
        errors++; $display("[TB] FAIL fair_result%0d got=%h/%b want=%h/%b", n, rsp_result, rsp_flags,
                           expRes[expOrder[n]], expFl[expOrder[n]]);
      end
      @(negedge clk);
    end
    req_valid = '0;
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (wins[r] != 1) begin errors++; $display("[TB] FAIL fair_wins%0d got=%0d want=1", r, wins[r]); end
    end
  endtask

  task automatic test_back_pressure();
    int stableBad = 0;
    rsp_ready = 1'b0;
    applyStimulus(1, OP_ADD_U, 16'h0010, 16'h0020);
    applyStimulus(3, OP_SUB_U, 16'h0005, 16'h0007);
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL bp_first_grant got=%b want=0010", req_ready); end
    @(negedge clk);
    dropRequest(1);
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      #1;
      if (rsp_valid === 1'b1) break;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 16'h0030 || rsp_id !== 2'd1) begin
      errors++; $display("[TB] FAIL bp_first_rsp got valid=%b res=%h id=%0d want 1/0030/1", rsp_valid, rsp_result, rsp_id);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (rsp_valid !== 1'b1 || rsp_result !== 16'h0030 || rsp_id !== 2'd1 || rsp_flags !== 3'b000 ||
          req_ready !== 4'b0000 || alu_a !== 16'h0010) stableBad++;
    end
    checks++;
    if (stableBad != 0) begin errors++; $display("[TB] FAIL bp_hold got=%0d unstable cycles want=0", stableBad); end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL bp_no_early_grant got=%b want=0000", req_ready); end
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin
      errors++; $display("[TB] FAIL bp_next_grant got valid=%b ready=%b want 0/1000", rsp_valid, req_ready);
    end
    @(negedge clk);
    dropRequest(3);
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      #1;
      if (rsp_valid === 1'b1) break;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_result !== 16'hFFFE || rsp_flags !== 3'b010) begin
      errors++; $display("[TB] FAIL bp_second_rsp got valid=%b id=%0d res=%h flags=%b want 1/3/fffe/010",
                         rsp_valid, rsp_id, rsp_result, rsp_flags);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_busy();
    int stray = 0;
    rsp_ready = 1'b1;
    applyStimulus(1, OP_ADD_U, 16'h0001, 16'h0002);
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL rst_busy_grant got=%b want=0010", req_ready); end
    @(negedge clk);
    dropRequest(1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, OP_ADD_U, 16'h0001, 16'h0001);
    applyStimulus(2, OP_ADD_U, 16'h0002, 16'h0002);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || alu_a !== 16'h0000) begin
      errors++; $display("[TB] FAIL rst_busy_clear got valid=%b alu_a=%h want 0/0000", rsp_valid, alu_a);
    end
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL rst_busy_regrant got=%b want=0001", req_ready); end
    @(negedge clk);
    dropRequest(0);
    dropRequest(2);
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      #1;
      if (rsp_valid === 1'b1) break;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 16'h0002) begin
      errors++; $display("[TB] FAIL rst_busy_rsp got valid=%b id=%0d res=%h want 1/0/0002", rsp_valid, rsp_id, rsp_result);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (rsp_valid !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("[TB] FAIL rst_busy_stray got=%0d responses want=0", stray); end
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    logic [3:0] rdy; int cyc; logic [1:0] id; logic [15:0] res; logic [2:0] fl;
    pulseReset();
    #1;
    checks++;
    if (stat_ops !== 64'h0) begin errors++; $display("[TB] FAIL stats_reset got=%h want=0", stat_ops); end
    for (int k = 0; k < 3; k++) issueAndCollect(1, OP_OR, 16'h0001, 16'h0002, rdy, cyc, id, res, fl);
    issueAndCollect(3, OP_XOR, 16'h00FF, 16'h000F, rdy, cyc, id, res, fl);
    @(negedge clk);
    #1;
    checks++;
    if (stat_ops[15:0] !== 16'd0) begin errors++; $display("[TB] FAIL stats_req0 got=%0d want=0", stat_ops[15:0]); end
    checks++;
    if (stat_ops[31:16] !== 16'd3) begin errors++; $display("[TB] FAIL stats_req1 got=%0d want=3", stat_ops[31:16]); end
    checks++;
    if (stat_ops[47:32] !== 16'd0) begin errors++; $display("[TB] FAIL stats_req2 got=%0d want=0", stat_ops[47:32]); end
    checks++;
    if (stat_ops[63:48] !== 16'd1) begin errors++; $display("[TB] FAIL stats_req3 got=%0d want=1", stat_ops[63:48]); end
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_op();
    test_wrap_zero();
    test_fairness();
    test_back_pressure();
    test_reset_mid_busy();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
